rf_32: RTL and testbench



---
 rtl/rf_32_if.sv | 37 +++
 rtl/rf_32.sv | 39 +++
 tb/tb_rf_32.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rf_32_if.sv
// Port bundle for the 32x32 register file.
// Read/write requests in, registered read data and finish out.
interface rf_32_if;
  logic        read_enabled;
  logic [4:0]  read_addr_s;
  logic [4:0]  read_addr_t;
  logic        write_enabled;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] outA;
  logic [31:0] outB;
  logic        finish;

  modport master (
    output read_enabled,
    output read_addr_s,
    output read_addr_t,
    output write_enabled,
    output write_addr,
    output write_data,
    input  outA,
    input  outB,
    input  finish
  );

  modport slave (
    input  read_enabled,
    input  read_addr_s,
    input  read_addr_t,
    input  write_enabled,
    input  write_addr,
    input  write_data,
    output outA,
    output outB,
    output finish
  );
endinterface

// File: rtl/rf_32.sv
// 32-entry x 32-bit register file, two sync read ports, one write.
// Reads are write-first; finish strobes after any enabled edge.
module rf_32 (
  input logic    clock,
  input logic    reset_n,
  rf_32_if.slave bus
);
  logic [31:0] register_file [0:31];
  logic        fwd_a;
  logic        fwd_b;

  // Same-edge write to a read address is forwarded to that port.
  assign fwd_a = bus.write_enabled &&
                 (bus.write_addr == bus.read_addr_s);
  assign fwd_b = bus.write_enabled &&
                 (bus.write_addr == bus.read_addr_t);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        register_file[i] <= '0;
      end
      bus.outA   <= '0;
      bus.outB   <= '0;
      bus.finish <= 1'b0;
    end else begin
      if (bus.write_enabled) begin
        register_file[bus.write_addr] <= bus.write_data;
      end
      if (bus.read_enabled) begin
        bus.outA <= fwd_a ? bus.write_data
                          : register_file[bus.read_addr_s];
        bus.outB <= fwd_b ? bus.write_data
                          : register_file[bus.read_addr_t];
      end
      bus.finish <= bus.read_enabled | bus.write_enabled;
    end
  end
endmodule

// File: tb/tb_rf_32.sv
// Self-checking bench for rf_32 against an array-based model.
// Directed phases followed by randomized traffic.
module tb_rf_32;
  logic clock;
  logic reset_n;
  rf_32_if bus ();

  rf_32 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int errors;

  logic [31:0] mem [0:31];
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic        exp_f;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic step(input logic rst, input logic re,
                      input logic [4:0] s, input logic [4:0] t,
                      input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    reset_n           = rst;
    bus.read_enabled  = re;
    bus.read_addr_s   = s;
    bus.read_addr_t   = t;
    bus.write_enabled = we;
    bus.write_addr    = wa;
    bus.write_data    = wd;
    if (!rst) begin
      foreach (mem[i]) mem[i] = '0;
      exp_a = '0;
      exp_b = '0;
      exp_f = 1'b0;
    end else begin
      if (re) begin
        exp_a = (we && wa == s) ? wd : mem[s];
        exp_b = (we && wa == t) ? wd : mem[t];
      end
      if (we) mem[wa] = wd;
      exp_f = re | we;
    end
    @(posedge clock);
    #1;
    chk("outA", bus.outA, exp_a);
    chk("outB", bus.outB, exp_b);
    chk("finish", {31'b0, bus.finish}, {31'b0, exp_f});
  endtask

  task automatic chk_mem(input logic [4:0] a);
    chk("register_file", dut.register_file[a], mem[a]);
  endtask

  initial begin
    logic [31:0] v;
    checks = 0;
    errors = 0;
    foreach (mem[i]) mem[i] = 'x;
    exp_a = 'x;
    exp_b = 'x;
    exp_f = 1'bx;
    reset_n           = 1'b1;
    bus.read_enabled  = 1'b0;
    bus.read_addr_s   = '0;
    bus.read_addr_t   = '0;
    bus.write_enabled = 1'b0;
    bus.write_addr    = '0;
    bus.write_data    = '0;
    @(negedge clock);

    // Uninitialised reads return X.
    for (int i = 0; i < 32; i += 2)
      step(1, 1, i[4:0], 5'(i + 1), 0, 0, 0);

    // Reset with a write request that must be discarded.
    step(0, 1, 3, 4, 1, 7, 32'h12345678);
    for (int i = 0; i < 32; i++) chk_mem(i[4:0]);
    for (int i = 0; i < 32; i += 2)
      step(1, 1, i[4:0], 5'(i + 1), 0, 0, 0);

    // Sequential writes.
    for (int i = 0; i < 32; i++) begin
      if (i == 0 || i == 31) v = 32'hDEADBEEF;
      else if (i == 1) v = 32'h0;
      else if (i <= 16) v = 32'h11111111 * (i - 1);
      else v = i - 16;
      step(1, 0, 0, 0, 1, i[4:0], v);
      chk_mem(i[4:0]);
    end
    chk("val_a", dut.register_file[10], 32'h99999999);
    chk("val_b", dut.register_file[30], 32'd14);

    // Independent port sweeps.
    for (int i = 0; i < 32; i++)
      step(1, 1, i[4:0], 0, 0, 0, 0);
    for (int i = 0; i < 32; i++)
      step(1, 1, 0, i[4:0], 0, 0, 0);

    // Hold with changing addresses.
    step(1, 1, 9, 12, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 5'($urandom), 5'($urandom), 0, 0, 0);
    chk("hold_a", bus.outA, 32'h88888888);

    // Forwarding.
    step(1, 1, 5, 6, 1, 5, 32'hCAFEF00D);
    chk("fwd_a", bus.outA, 32'hCAFEF00D);
    chk("fwd_b", bus.outB, 32'h55555555);

    // Finish strobe: one enabled cycle, then idle.
    step(1, 1, 1, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 40) != 0),
           1'($urandom), 5'($urandom), 5'($urandom),
           1'($urandom), 5'($urandom), $urandom);
      chk_mem(5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
